// File: rtl/mem_pkg.sv
// Shared memory-access definitions: op encoding used by the MEM-stage decoder
// and the load-extend unit, plus the RMW controller state encoding.
package mem_pkg;

  localparam logic [1:0] MEM_OP_B   = 2'b00;
  localparam logic [1:0] MEM_OP_H   = 2'b01;
  localparam logic [1:0] MEM_OP_W   = 2'b10;
  localparam logic [1:0] MEM_OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  // An access is rejected when the op is reserved or the address is not
  // naturally aligned for its size.
  function automatic logic is_bad_access(input logic [1:0] op, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (op)
      MEM_OP_H: bad = off[0];
      MEM_OP_W: bad = (off != 2'b00);
      MEM_OP_B: bad = 1'b0;
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lane_merge.sv
// Byte/half lane merge for sub-word stores: replaces the addressed lane of the
// old DRAM word with the store data, leaving the other lanes untouched.
module lane_merge
  import mem_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] old_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] merged_o
);

  // Select the lane from the byte offset; word/reserved ops pass the old word.
  always_comb begin
    merged_o = old_i;
    case (op_i)
      MEM_OP_B: begin
        case (off_i)
          2'd0: merged_o[7:0]   = wdata_i[7:0];
          2'd1: merged_o[15:8]  = wdata_i[7:0];
          2'd2: merged_o[23:16] = wdata_i[7:0];
          2'd3: merged_o[31:24] = wdata_i[7:0];
        endcase
      end
      MEM_OP_H: begin
        if (off_i[1]) merged_o[31:16] = wdata_i;
        else          merged_o[15:0]  = wdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_rmw_ctrl.sv
// MEM-stage data-memory controller. Loads read one DRAM word; word stores write
// directly; byte/half stores do read-merge-write. Misaligned or reserved ops
// return an error response without touching DRAM.
//
// Handshake: a request is taken in any cycle where req_valid=1 and req_ready=1
// (req_ready is high only in IDLE). Request inputs are ignored at all other
// times. Every accepted request produces exactly one resp_valid pulse, and
// req_ready stays low from the cycle after acceptance until after that pulse.
module mem_rmw_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] dram_addr,
  output logic              dram_we,
  output logic [31:0]       dram_wdata,
  input  logic [31:0]       dram_rdata
);

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_e            state_q;
  logic [1:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        op_q;
  logic [1:0]        off_q;
  logic [15:0]       wdata_q;
  logic              store_q;
  logic              err_q;
  logic [31:0]       merged_q;
  logic [31:0]       rdata_q;
  logic [31:0]       merged;

  logic acc_err;
  logic acc_sw;
  logic wr_now;
  logic unused_addr_hi;

  // High address bits are deliberately dropped: no range check.
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign acc_err = is_bad_access(req_op, req_addr[1:0]);
  assign acc_sw  = (state_q == ST_IDLE) & req_valid & req_we &
                   (req_op == MEM_OP_W) & ~acc_err;
  // Gated by reset so a pending write is abandoned the moment reset arrives.
  assign wr_now  = rst_n & (acc_sw | (state_q == ST_WRITE));

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = (state_q == ST_RESP) & err_q;
  assign resp_rdata = rdata_q;
  assign dram_we    = wr_now;

  lane_merge u_lane_merge (
    .op_i    (op_q),
    .off_i   (off_q),
    .old_i   (dram_rdata),
    .wdata_i (wdata_q),
    .merged_o(merged)
  );

  // DRAM address/data: live request address in IDLE, held address while busy.
  always_comb begin
    dram_addr  = '0;
    dram_wdata = '0;
    case (state_q)
      ST_IDLE:               dram_addr = req_valid ? req_addr[ADDR_W+1:2] : '0;
      ST_RD_WAIT, ST_WRITE:  dram_addr = addr_q;
      default:               dram_addr = '0;
    endcase
    if (wr_now) dram_wdata = (state_q == ST_WRITE) ? merged_q : req_wdata;
  end

  // Controller FSM with wait counter and request capture registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      op_q     <= '0;
      off_q    <= '0;
      wdata_q  <= '0;
      store_q  <= 1'b0;
      err_q    <= 1'b0;
      merged_q <= '0;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr[ADDR_W+1:2];
            op_q    <= req_op;
            off_q   <= req_addr[1:0];
            wdata_q <= req_wdata[15:0];
            store_q <= req_we;
            cnt_q   <= CNT_INIT;
            err_q   <= acc_err;
            if (acc_err || acc_sw) state_q <= ST_RESP;
            else                   state_q <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (cnt_q == 2'd0) begin
            if (store_q) begin
              merged_q <= merged;
              state_q  <= ST_WRITE;
            end else begin
              rdata_q <= dram_rdata;
              state_q <= ST_RESP;
            end
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        ST_WRITE: state_q <= ST_RESP;
        ST_RESP: begin
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
